// File: rtl/ram_point_streamer.sv
// Streams points from two paired SRAMs through a 2-deep FIFO to the core.
// Define STREAMER_PT_CNT_EN to add the point_cnt transferred-point counter.
module ram_point_streamer #(
    parameter int addrWidth    = 9,
    parameter int dataWidth    = 91,
    parameter int ram_word_len = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [addrWidth-1:0]    first_ram_addr,
    input  logic [addrWidth-1:0]    last_ram_addr,
    output logic [addrWidth-1:0]    ram_addr,
    output logic                    csb,
    output logic                    oeb,
    output logic                    web,
    input  logic [ram_word_len-1:0] ram1_dout,
    input  logic [ram_word_len-1:0] ram2_dout,
    output logic [dataWidth-1:0]    point_data,
    output logic                    point_valid,
    input  logic                    point_ready,
    output logic                    point_last,
`ifdef STREAMER_PT_CNT_EN
    output logic [addrWidth:0]      point_cnt,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    addr_err
);
    localparam int HiW = dataWidth - ram_word_len;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t               r_state;
    logic [addrWidth-1:0] r_addr;
    logic [addrWidth-1:0] r_last_addr;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_addr_err;

    logic                 r_pend;
    logic                 r_pend_last;
    logic [dataWidth-1:0] r_fifo_data [2];
    logic [1:0]           r_fifo_last;
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_cnt;

    logic                 w_pop;
    logic                 w_issue;
    logic                 w_at_last;
    logic                 w_flush;
    logic                 w_head_last;
    logic [2:0]           w_credit;
    logic [dataWidth-1:0] w_merged;
    logic                 w_unused;

    assign w_merged    = {ram2_dout[HiW-1:0], ram1_dout};
    assign w_unused    = ^ram2_dout[ram_word_len-1:HiW];
    assign w_head_last = r_fifo_last[r_rd_ptr];
    assign w_pop       = (r_cnt != 2'd0) && point_ready;
    assign w_at_last   = (r_addr == r_last_addr);
    assign w_flush     = abort && ((r_state == READ) || (r_state == DRAIN));

    // Occupancy after this edge plus the read still in the SRAM; a pop this
    // cycle frees its slot so a ready core sees one point per cycle.
    assign w_credit = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_issue  = (r_state == READ) && !abort && (w_credit < 3'd2);

    // Select is combinational so the SRAM samples on the deciding edge.
    assign csb         = !w_issue;
    assign oeb         = !w_issue;
    assign web         = 1'b1;
    assign ram_addr    = r_addr;
    assign point_valid = (r_cnt != 2'd0);
    assign point_data  = r_fifo_data[r_rd_ptr];
    assign point_last  = point_valid && w_head_last;
    assign busy        = r_busy;
    assign done        = r_done;
    assign addr_err    = r_addr_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_last_addr <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (first_ram_addr <= last_ram_addr) begin
                            r_state     <= READ;
                            r_addr      <= first_ram_addr;
                            r_last_addr <= last_ram_addr;
                            r_addr_err  <= 1'b0;
                        end else begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_addr_err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_issue) begin
                        if (w_at_last) begin
                            r_state <= DRAIN;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_pop && w_head_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_fifo_data <= '{default: '0};
            r_fifo_last <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_cnt       <= 2'd0;
        end else if (w_flush) begin
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_cnt       <= 2'd0;
        end else begin
            r_pend      <= w_issue;
            r_pend_last <= w_issue && w_at_last;
            if (r_pend) begin
                r_fifo_data[r_wr_ptr] <= w_merged;
                r_fifo_last[r_wr_ptr] <= r_pend_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end

`ifdef STREAMER_PT_CNT_EN
    logic [addrWidth:0] r_pt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pt_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_pt_cnt <= '0;
        end else if (w_pop && !w_flush) begin
            r_pt_cnt <= r_pt_cnt + 1'b1;
        end
    end

    assign point_cnt = r_pt_cnt;
`endif

endmodule

// File: tb/tb_ram_point_streamer.sv
// Directed bench for ram_point_streamer: SRAM model plus in-order scoreboard.
// Expected points are queued when a pass starts and popped on each transfer.
`timescale 1ns/1ps
module tb_ram_point_streamer;
    localparam int AW = 9;
    localparam int DW = 91;
    localparam int RW = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          point_ready = 1'b0;
    logic [AW-1:0] first_ram_addr = '0;
    logic [AW-1:0] last_ram_addr = '0;
    logic [AW-1:0] ram_addr;
    logic          csb, oeb, web;
    logic [RW-1:0] ram1_dout, ram2_dout;
    logic [DW-1:0] point_data;
    logic          point_valid, point_last, busy, done, addr_err;
`ifdef STREAMER_PT_CNT_EN
    logic [AW:0]   point_cnt;
`endif

    ram_point_streamer dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .first_ram_addr(first_ram_addr),
        .last_ram_addr(last_ram_addr),
        .ram_addr(ram_addr),
        .csb(csb),
        .oeb(oeb),
        .web(web),
        .ram1_dout(ram1_dout),
        .ram2_dout(ram2_dout),
        .point_data(point_data),
        .point_valid(point_valid),
        .point_ready(point_ready),
        .point_last(point_last),
`ifdef STREAMER_PT_CNT_EN
        .point_cnt(point_cnt),
`endif
        .busy(busy),
        .done(done),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    logic [RW-1:0] mem1 [512];
    logic [RW-1:0] mem2 [512];

    // Synchronous SRAM pair: output appears after the edge that samples csb.
    always @(posedge clk) begin
        if (!csb && !oeb) begin
            ram1_dout <= mem1[ram_addr];
            ram2_dout <= mem2[ram_addr];
        end
    end

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            tx_k[$];
    int            vecs = 0;
    int            errs = 0;
    int            k, done_n, done_k, csb_low_n, valid_n, first_v_k;
    logic          held_v = 1'b0;
    logic          held_l;
    logic [DW-1:0] held_d;
    logic [DW-1:0] last_pop;

    task automatic chk(input string tag, input logic [DW:0] obs,
                       input logic [DW:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        k = 0;
        done_n = 0;
        done_k = -1;
        csb_low_n = 0;
        valid_n = 0;
        first_v_k = -1;
        tx_k.delete();
    endtask

    // Check the handshake about to happen, then advance one clock.
    task automatic cycle();
        exp_t e;
        if (held_v) begin
            chk("stall_valid", point_valid, 1'b1);
            chk("stall_data", {point_last, point_data}, {held_l, held_d});
        end
        if (point_valid && point_ready) begin
            if (sb.size() == 0) begin
                chk("extra_point", point_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("point", {point_last, point_data}, e);
                tx_k.push_back(k);
                last_pop = point_data;
            end
        end
        held_v = point_valid && !point_ready;
        held_d = point_data;
        held_l = point_last;
        @(posedge clk);
        @(negedge clk);
        k++;
        if (done) begin
            done_n++;
            done_k = k;
        end
        if (!csb) csb_low_n++;
        if (point_valid) begin
            valid_n++;
            if (first_v_k < 0) first_v_k = k;
        end
    endtask

    task automatic begin_pass(input int f, input int l, input logic rdy);
        exp_t e;
        first_ram_addr = AW'(f);
        last_ram_addr = AW'(l);
        start = 1'b1;
        point_ready = rdy;
        clr_counts();
        if (f <= l) begin
            for (int a = f; a <= l; a++) begin
                e.last = (a == l);
                e.data = {mem2[a][DW-RW-1:0], mem1[a]};
                sb.push_back(e);
            end
        end
        cycle();
        start = 1'b0;
    endtask

    // m=0: ready held high; m=1: ready toggles 1010. rs: cycle of a stray start.
    task automatic run_pass(input int f, input int l, input int m,
                            input int rs, input int budget);
        begin_pass(f, l, 1'b1);
        while (done_n == 0 && k < budget) begin
            point_ready = (m == 0) ? 1'b1 : ((k % 2) == 0);
            start = (k == rs);
            if (start) begin
                first_ram_addr = 9'd100;
                last_ram_addr = 9'd200;
            end
            cycle();
            start = 1'b0;
        end
        if (done_n == 0) chk("done_timeout", done, 1'b1);
        cycle();
        chk("done_pulse_count", done_n, 1);
        chk("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 512; a++) begin
            mem1[a] = RW'({$urandom(), $urandom()});
            mem2[a] = RW'({$urandom(), $urandom()});
        end
        mem1[1] = 50'd6;
        mem1[2] = 50'd12;
        mem1[3] = 50'd7;
        mem2[1] = '0;
        mem2[2] = '0;
        mem2[3] = '0;
        mem1[20] = '1;
        mem2[20] = 50'h1_FFFF_FFFF_FFFF;

        repeat (2) @(negedge clk);
        chk("rst_csb", csb, 1'b1);
        chk("rst_oeb", oeb, 1'b1);
        chk("rst_web", web, 1'b1);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_valid", point_valid, 1'b0);
        chk("rst_last", point_last, 1'b0);
        chk("rst_data", point_data, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr_err", addr_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1..3 at full rate: valid two edges after the start-sampling edge.
        run_pass(1, 3, 0, -1, 40);
        chk("p13_count", tx_k.size(), 3);
        chk("p13_latency", first_v_k, 3);
        chk("p13_back_to_back", tx_k[2] - tx_k[0], 2);
        chk("p13_done_after_last", done_k, tx_k[2] + 1);
        chk("p13_reads", csb_low_n, 3);

        run_pass(4, 2, 0, -1, 10);
        chk("err_flag", addr_err, 1'b1);
        chk("err_no_sram", csb_low_n, 0);
        chk("err_no_valid", valid_n, 0);

        run_pass(5, 5, 0, -1, 20);
        chk("single_count", tx_k.size(), 1);
        chk("err_cleared", addr_err, 1'b0);
`ifdef STREAMER_PT_CNT_EN
        chk("single_pt_cnt", point_cnt, 1);
`endif

        run_pass(0, 7, 1, 4, 80);
        chk("toggle_count", tx_k.size(), 8);
        chk("toggle_sb_empty", sb.size(), 0);

        run_pass(20, 20, 0, -1, 20);
        chk("all_ones", last_pop, {DW{1'b1}});

        begin_pass(0, 511, 1'b1);
        while (tx_k.size() < 3 && k < 40) cycle();
        abort = 1'b1;
        point_ready = 1'b0;
        cycle();
        abort = 1'b0;
        held_v = 1'b0;
        sb.delete();
        chk("abort_valid", point_valid, 1'b0);
        chk("abort_csb", csb, 1'b1);
        chk("abort_busy", busy, 1'b0);
        clr_counts();
        repeat (4) cycle();
        chk("abort_no_done", done_n, 0);
        chk("abort_idle_csb", csb_low_n, 0);

        begin_pass(0, 511, 1'b0);
        repeat (5) cycle();
        rst_n = 1'b0;
        held_v = 1'b0;
        sb.delete();
        #1;
        chk("midrst_valid", point_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        clr_counts();
        repeat (4) cycle();
        chk("midrst_no_done", done_n, 0);
        chk("midrst_no_valid", valid_n, 0);

        run_pass(509, 511, 0, -1, 40);
        chk("top_count", tx_k.size(), 3);
        chk("top_reads", csb_low_n, 3);
        chk("top_no_wrap", ram_addr, 511);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ram_point_streamer.md
RAM_POINT_STREAMER -- requirements
Module: ram_point_streamer

Interface
REQ-001 Parameter addrWidth, default 9, SRAM address width.
REQ-002 Parameter dataWidth, default 91, merged point width.
REQ-003 Parameter ram_word_len, default 50, single-SRAM word width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins a pass.
REQ-008 abort  in  1  synchronous pass cancel.
REQ-009 first_ram_addr  in  addrWidth  first point address, inclusive.
REQ-010 last_ram_addr  in  addrWidth  last point address, inclusive.
REQ-011 ram_addr  out  addrWidth  shared address to both SRAMs.
REQ-012 csb  out  1  SRAM chip select, active-low.
REQ-013 oeb  out  1  SRAM output enable, active-low.
REQ-014 web  out  1  SRAM write enable, active-low; tied 1.
REQ-015 ram1_dout  in  ram_word_len  SRAM1 output.
REQ-016 ram2_dout  in  ram_word_len  SRAM2 output.
REQ-017 point_data  out  dataWidth  merged point to core.
REQ-018 point_valid  out  1  point_data valid.
REQ-019 point_ready  in  1  core accepts point.
REQ-020 point_last  out  1  marks point from last_ram_addr.
REQ-021 busy  out  1  pass in progress.
REQ-022 done  out  1  one-cycle pulse at pass end.
REQ-023 addr_err  out  1  sticky; first_ram_addr > last_ram_addr at start.

Function
REQ-024 FSM states SHALL be IDLE, READ, DRAIN, DONE.
REQ-025 IDLE: start with first<=last -> READ, latch both addresses, busy=1; start with first>last -> DONE, addr_err=1, no SRAM access.
REQ-026 READ: csb=0, oeb=0 while issuing; SRAM data SHALL be captured exactly one cycle after the issuing edge.
REQ-027 A read SHALL be issued only when buffer occupancy plus reads in flight is below 2.
REQ-028 Merge: point_data[ram_word_len-1:0]=ram1_dout; point_data[dataWidth-1:ram_word_len]=ram2_dout[dataWidth-ram_word_len-1:0].
REQ-029 A 2-entry FIFO SHALL hold captured points; point_valid=FIFO non-empty; transfer on point_valid&&point_ready.
REQ-030 point_data/point_last SHALL hold stable while point_valid&&!point_ready.
REQ-031 Addresses SHALL be issued in ascending order without skip or repeat; after issuing last_ram_addr -> DRAIN, csb=1.
REQ-032 DRAIN -> DONE when the point with point_last=1 transfers; DONE asserts done one cycle -> IDLE, busy=0.
REQ-033 first==last SHALL yield exactly one point with point_last=1.
REQ-034 Address 511 as last SHALL terminate without counter wrap to 0.
REQ-035 start while busy SHALL be ignored.
REQ-036 abort in READ/DRAIN SHALL flush FIFO and in-flight read, csb=1, point_valid=0 next cycle, -> IDLE without done.
REQ-037 With point_ready held 1, throughput SHALL be one point per cycle; first point_valid 2 cycles after start.
REQ-038 addr_err SHALL clear on the next start with first<=last.

Reset
REQ-039 On rst_n=0: state IDLE, csb=1, oeb=1, web=1, ram_addr=0, point_valid=0, point_last=0, point_data=0, busy=0, done=0, addr_err=0, FIFO empty.
REQ-040 Reset mid-pass SHALL discard all points; no done pulse.

Configuration
REQ-041 Macro STREAMER_PT_CNT_EN defined: output point_cnt [addrWidth:0] counts transferred points, cleared at start, held after done; undefined: port and counter absent, other behaviour identical.

Verification
REQ-042 first=1,last=3, SRAM1={6,12,7}, SRAM2=0, ready=1 -> points 6,12,7 on consecutive cycles, point_last on 7, done one cycle later.
REQ-043 first=5,last=5 -> single point, point_last=1, done; point_cnt=1 with STREAMER_PT_CNT_EN.
REQ-044 first=0,last=7, ready toggling 1010 -> all 8 points in order, data stable during stalls, no duplicates.
REQ-045 first=4,last=2 -> addr_err=1, done pulse, csb stays 1, no point_valid.
REQ-046 first=0,last=511, abort after 3rd transfer -> point_valid=0 next cycle, csb=1, IDLE, no done.
REQ-047 SRAM1=all ones, SRAM2=0x1_FFFF_FFFF_FFFF -> point_data all 91 bits ones; ram2 bits 49:41 ignored.
